// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS sequencer (master) and its datapath (slave).
interface mips_multicycle_ctrl_if;
  logic       start;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [3:0] state;
  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal;
  logic       timeout;

  modport master (
    input  start, opcode, zero, mem_ready,
    output state, pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal, timeout
  );

  modport slave (
    output start, opcode, zero, mem_ready,
    input  state, pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal, timeout
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Opcode-driven multicycle MIPS sequencer with memory-ready stalls and a sticky FAULT state
// for illegal opcodes and memory wait timeouts.
module mips_multicycle_ctrl #(
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam int CW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12, S_FAULT  = 4'd15
  } state_t;

  state_t        st, nx;
  logic [CW-1:0] wcnt;
  logic          illegal_q, timeout_q;
  logic          wait_st, wait_to, bad_op, fin;

  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;

  // Wait counting only runs while stalled in a memory-access state.
  assign wait_st = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
  assign wait_to = wait_st && !bus.mem_ready && (wcnt == CW'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st        <= S_IDLE;
      wcnt      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      st   <= nx;
      wcnt <= (wait_st && !bus.mem_ready) ? wcnt + 1'b1 : '0;
      if (bad_op)  illegal_q <= 1'b1;
      if (wait_to) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    nx         = st;
    fin        = 1'b0;
    bad_op     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    case (st)
      S_IDLE: if (bus.start) nx = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) nx = S_DECODE;
        else if (wait_to)  nx = S_FAULT;
      end
      S_DECODE: begin
        // Speculative branch target goes into ALUOut while the opcode is decoded.
        alu_src_b = 2'b11;
        case (bus.opcode)
          6'h00:        nx = S_EXEC;
          6'h23, 6'h2B: nx = S_MEMADR;
          6'h04:        nx = S_BRANCH;
          6'h02:        nx = S_JUMP;
          6'h08:        nx = S_ADDIEX;
          default: begin
            nx     = S_FAULT;
            bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nx        = (bus.opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) nx = S_MEMWB;
        else if (wait_to)  nx = S_FAULT;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        fin        = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) fin = 1'b1;
        else if (wait_to)  nx  = S_FAULT;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nx        = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        fin       = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = bus.zero;
        fin       = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        fin      = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nx        = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        fin       = 1'b1;
      end
      S_FAULT: nx = S_FAULT;
      default: nx = S_FAULT;
    endcase
    if (fin) nx = bus.start ? S_FETCH : S_IDLE;
  end

  assign bus.state      = st;
  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.iord       = iord;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_src     = pc_src;
  assign bus.instr_done = fin;
  assign bus.illegal    = illegal_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: instruction paths, stalls, faults and async reset.
module tb_mips_multicycle_ctrl;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.WAIT_TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // All control strobes packed together so idle/reset/fault checks are one compare.
  function automatic logic [31:0] strobes();
    return {14'd0, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.iord,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.instr_done};
  endfunction

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.opcode    = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    chk("rst_state", bus.state, 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_flags", {bus.illegal, bus.timeout}, 0);
    reset = 1'b0;
    tick();
    chk("idle_state", bus.state, 0);
    chk("idle_strobes", strobes(), 0);

    // R-type: 1,2,7,8
    bus.start = 1'b1;
    tick();
    chk("r_fetch", bus.state, 1);
    chk("r_fetch_ctl", {bus.mem_read, bus.ir_write, bus.pc_write, bus.alu_src_b, bus.pc_src}, 7'b111_01_00);
    tick();
    chk("r_decode", bus.state, 2);
    chk("r_decode_srcb", bus.alu_src_b, 2'b11);
    tick();
    chk("r_exec", bus.state, 7);
    chk("r_exec_ctl", {bus.alu_src_a, bus.alu_op}, 3'b1_10);
    tick();
    chk("r_aluwb", bus.state, 8);
    chk("r_aluwb_ctl", {bus.reg_write, bus.reg_dst, bus.instr_done}, 3'b111);

    // lw with 3 stall cycles in MEMRD: 1,2,3,4,4,4,4,5
    bus.opcode = 6'h23;
    tick();
    chk("lw_fetch", bus.state, 1);
    tick();
    chk("lw_decode", bus.state, 2);
    tick();
    chk("lw_memadr", bus.state, 3);
    chk("lw_memadr_ctl", {bus.alu_src_a, bus.alu_src_b}, 3'b1_10);
    bus.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_memrd_wait", bus.state, 4);
      chk("lw_memrd_ctl", {bus.mem_read, bus.iord, bus.instr_done}, 3'b110);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("lw_memrd_done", bus.state, 4);
    tick();
    chk("lw_memwb", bus.state, 5);
    chk("lw_memwb_ctl", {bus.reg_write, bus.mem_to_reg, bus.instr_done}, 3'b111);

    // beq taken then not taken, then stop
    bus.opcode = 6'h04;
    bus.zero   = 1'b1;
    tick();
    chk("beq1_fetch", bus.state, 1);
    tick();
    chk("beq1_decode", bus.state, 2);
    tick();
    chk("beq1_branch", bus.state, 9);
    chk("beq1_ctl", {bus.pc_write, bus.pc_src, bus.alu_op, bus.alu_src_a, bus.instr_done}, 7'b1_01_01_1_1);
    bus.zero = 1'b0;
    tick();
    chk("beq0_fetch", bus.state, 1);
    tick();
    chk("beq0_decode", bus.state, 2);
    tick();
    chk("beq0_branch", bus.state, 9);
    chk("beq0_pcw", {bus.pc_write, bus.instr_done}, 2'b01);
    bus.start = 1'b0;
    tick();
    chk("beq_to_idle", bus.state, 0);

    // addi: 1,2,11,12
    bus.start  = 1'b1;
    bus.opcode = 6'h08;
    tick();
    tick();
    tick();
    chk("addi_ex", bus.state, 11);
    chk("addi_ex_ctl", {bus.alu_src_a, bus.alu_src_b, bus.reg_write}, 4'b1_10_0);
    tick();
    chk("addi_wb", bus.state, 12);
    chk("addi_wb_ctl", {bus.reg_write, bus.reg_dst, bus.instr_done}, 3'b101);

    // jump, then async reset drops pc_write at once
    bus.opcode = 6'h02;
    tick();
    tick();
    tick();
    chk("j_state", bus.state, 10);
    chk("j_ctl", {bus.pc_write, bus.pc_src, bus.instr_done}, 4'b1_10_1);
    reset = 1'b1;
    #1;
    chk("j_rst_pcw", bus.pc_write, 0);
    chk("j_rst_state", bus.state, 0);
    tick();
    reset = 1'b0;

    // illegal opcode: sticky FAULT despite start=1
    bus.opcode = 6'h3F;
    tick();
    chk("ill_fetch", bus.state, 1);
    tick();
    chk("ill_decode", bus.state, 2);
    chk("ill_pre_flag", bus.illegal, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("ill_fault", {bus.state, bus.illegal}, {4'd15, 1'b1});
      chk("ill_strobes", strobes(), 0);
      tick();
    end
    reset = 1'b1;
    #1;
    chk("ill_rst", {bus.state, bus.illegal}, 0);
    tick();
    reset = 1'b0;

    // fetch timeout: 15 stalled cycles then FAULT
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'h00;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("to_fetch", bus.state, 1);
      chk("to_no_irw", {bus.ir_write, bus.timeout}, 0);
      tick();
    end
    chk("to_fault", {bus.state, bus.timeout, bus.ir_write}, {4'd15, 1'b1, 1'b0});
    bus.mem_ready = 1'b1;
    tick();
    chk("to_sticky", {bus.state, bus.timeout, bus.ir_write}, {4'd15, 1'b1, 1'b0});
    reset = 1'b1;
    #1;
    chk("to_rst", {bus.state, bus.timeout}, 0);
    tick();
    reset = 1'b0;

    // sw stalled in MEMWR, reset mid-write
    bus.opcode = 6'h2B;
    tick();
    tick();
    tick();
    chk("sw_memadr", bus.state, 3);
    bus.mem_ready = 1'b0;
    tick();
    chk("sw_memwr", bus.state, 6);
    chk("sw_wait_ctl", {bus.mem_write, bus.iord, bus.instr_done}, 3'b110);
    reset = 1'b1;
    #1;
    chk("sw_rst_mw", bus.mem_write, 0);
    chk("sw_rst_state", bus.state, 0);
    tick();
    reset = 1'b0;
    bus.mem_ready = 1'b1;

    // sw completing with start dropped: back to IDLE
    tick();
    chk("sw2_fetch", bus.state, 1);
    tick();
    tick();
    tick();
    bus.start = 1'b0;
    #1;
    chk("sw2_memwr", {bus.state, bus.mem_write, bus.instr_done}, {4'd6, 1'b1, 1'b1});
    tick();
    chk("sw2_idle", bus.state, 0);
    tick();
    chk("sw2_stay_idle", {bus.state, strobes()}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
